// File: rtl/trap_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package   : trap_pkg                                                     |
// | Purpose   : Shared types and constants for the machine-mode trap         |
// |             sequencer (state encoding, cause codes, mtvec mode, mip bit  |
// |             positions).                                                  |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
package trap_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    HANDLER = 2'd2
  } trap_state_e;

  localparam logic [3:0] CAUSE_MTI      = 4'd7;
  localparam logic [3:0] CAUSE_MEI      = 4'd11;
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;
  localparam int         MIP_MTIP_BIT   = 7;
  localparam int         MIP_MEIP_BIT   = 11;

endpackage : trap_pkg
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : sync_edge_det                                                |
// | Purpose   : Multi-flop synchroniser for an asynchronous level input,     |
// |             followed by a rising-edge detector on the synchronised level.|
// | Ports     : clk_i    - clock                                             |
// |             rst_ni   - asynchronous active-low reset                     |
// |             async_i  - asynchronous input level                          |
// |             rise_o   - one-cycle pulse on a synchronised 0->1 transition |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_i};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  // Pulse is combinational off the last sync flop so the pending bit
  // downstream can capture it on the very next edge.
  assign rise_o = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule : sync_edge_det
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : trap_ctrl                                                    |
// | Purpose   : Machine-mode interrupt/trap sequencer. Latches synchronised  |
// |             timer/external interrupt edges, arbitrates them, waits for a |
// |             valid instruction at commit, issues a one-cycle flush and    |
// |             CSR update, then tracks handler residency until mret.        |
// | Ports     : clk_i, rst_ni            - clock, async active-low reset     |
// |             t_intr_i, e_intr_i       - async timer / external requests   |
// |             mstatus_mie_i            - global interrupt enable           |
// |             mie_mtie_i, mie_meie_i   - per-source enables                |
// |             mtvec_i                  - trap vector base + mode           |
// |             commit_valid_i/commit_pc_i - instruction at commit           |
// |             mret_i                   - mret committing                   |
// |             trap_req_o, trap_pc_o    - flush + redirect target           |
// |             mepc_*/mcause_*          - CSR write strobes and data        |
// |             mie_clr_o, mie_restore_o - mstatus MIE/MPIE stack control    |
// |             mip_o                    - pending view                      |
// |             busy_o                   - handler active                    |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int DW          = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          t_intr_i,
  input  logic          e_intr_i,
  input  logic          mstatus_mie_i,
  input  logic          mie_mtie_i,
  input  logic          mie_meie_i,
  input  logic [DW-1:0] mtvec_i,
  input  logic          commit_valid_i,
  input  logic [DW-1:0] commit_pc_i,
  input  logic          mret_i,
  output logic          trap_req_o,
  output logic [DW-1:0] trap_pc_o,
  output logic          mepc_we_o,
  output logic [DW-1:0] mepc_o,
  output logic          mcause_we_o,
  output logic [DW-1:0] mcause_o,
  output logic          mie_clr_o,
  output logic          mie_restore_o,
  output logic [DW-1:0] mip_o,
  output logic          busy_o
);

  trap_state_e   r_state;
  trap_state_e   w_next_state;

  logic          w_t_rise;
  logic          w_e_rise;
  logic          r_mtip;
  logic          r_meip;

  logic          w_ext_ok;
  logic          w_tmr_ok;
  logic          w_eligible;
  logic [3:0]    w_code;
  logic          w_take;
  logic          w_take_ext;
  logic          w_take_tmr;

  logic [DW-1:0] w_base;
  logic [DW-1:0] w_vec_off;
  logic [DW-1:0] w_target;

  // --------------------------------------------------------------------
  // Input synchronisers
  // --------------------------------------------------------------------
  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_t (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .async_i (t_intr_i),
    .rise_o  (w_t_rise)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_e (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .async_i (e_intr_i),
    .rise_o  (w_e_rise)
  );

  // --------------------------------------------------------------------
  // Arbitration: external beats timer
  // --------------------------------------------------------------------
  assign w_ext_ok   = r_meip & mie_meie_i;
  assign w_tmr_ok   = r_mtip & mie_mtie_i;
  assign w_eligible = mstatus_mie_i & (w_ext_ok | w_tmr_ok);
  assign w_code     = w_ext_ok ? CAUSE_MEI : CAUSE_MTI;

  // Eligibility is re-qualified in the take cycle so a same-cycle MIE
  // clear and valid commit never produce a trap.
  assign w_take     = (r_state == ARMED) & w_eligible & commit_valid_i;
  assign w_take_ext = w_take & w_ext_ok;
  assign w_take_tmr = w_take & ~w_ext_ok;

  // --------------------------------------------------------------------
  // Pending bits: a new edge wins over the clear from being taken
  // --------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mtip <= 1'b0;
      r_meip <= 1'b0;
    end else begin
      r_mtip <= w_t_rise | (r_mtip & ~w_take_tmr);
      r_meip <= w_e_rise | (r_meip & ~w_take_ext);
    end
  end

  // --------------------------------------------------------------------
  // Redirect target
  // --------------------------------------------------------------------
  assign w_base    = {mtvec_i[DW-1:2], 2'b00};
  assign w_vec_off = {{(DW-6){1'b0}}, w_code, 2'b00};
  assign w_target  = (mtvec_i[1:0] == MTVEC_VECTORED) ? (w_base + w_vec_off) : w_base;

  // --------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    trap_req_o    = 1'b0;
    trap_pc_o     = '0;
    mepc_we_o     = 1'b0;
    mepc_o        = '0;
    mcause_we_o   = 1'b0;
    mcause_o      = '0;
    mie_clr_o     = 1'b0;
    mie_restore_o = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_eligible) begin
          w_next_state = ARMED;
        end
      end
      ARMED: begin
        if (!w_eligible) begin
          w_next_state = IDLE;
        end else if (commit_valid_i) begin
          w_next_state = HANDLER;
          trap_req_o   = 1'b1;
          trap_pc_o    = w_target;
          mepc_we_o    = 1'b1;
          mepc_o       = commit_pc_i;
          mcause_we_o  = 1'b1;
          mcause_o     = {1'b1, {(DW-5){1'b0}}, w_code};
          mie_clr_o    = 1'b1;
        end
      end
      HANDLER: begin
        if (mret_i) begin
          w_next_state  = IDLE;
          mie_restore_o = 1'b1;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------
  // Status outputs
  // --------------------------------------------------------------------
  always_comb begin
    mip_o               = '0;
    mip_o[MIP_MTIP_BIT] = r_mtip;
    mip_o[MIP_MEIP_BIT] = r_meip;
  end

  assign busy_o = (r_state == HANDLER);

endmodule : trap_ctrl
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tb_trap_ctrl                                                 |
// | Purpose   : Directed self-checking bench for trap_ctrl (direct/vectored  |
// |             traps, arbitration, masking, bubble hold, reset).            |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module tb_trap_ctrl;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          t_intr, e_intr;
  logic          mstatus_mie, mtie, meie;
  logic [DW-1:0] mtvec;
  logic          commit_valid;
  logic [DW-1:0] commit_pc;
  logic          mret;
  logic          trap_req;
  logic [DW-1:0] trap_pc;
  logic          mepc_we;
  logic [DW-1:0] mepc;
  logic          mcause_we;
  logic [DW-1:0] mcause;
  logic          mie_clr;
  logic          mie_restore;
  logic [DW-1:0] mip;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  trap_ctrl #(.DW(DW), .SYNC_STAGES(2)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .t_intr_i       (t_intr),
    .e_intr_i       (e_intr),
    .mstatus_mie_i  (mstatus_mie),
    .mie_mtie_i     (mtie),
    .mie_meie_i     (meie),
    .mtvec_i        (mtvec),
    .commit_valid_i (commit_valid),
    .commit_pc_i    (commit_pc),
    .mret_i         (mret),
    .trap_req_o     (trap_req),
    .trap_pc_o      (trap_pc),
    .mepc_we_o      (mepc_we),
    .mepc_o         (mepc),
    .mcause_we_o    (mcause_we),
    .mcause_o       (mcause),
    .mie_clr_o      (mie_clr),
    .mie_restore_o  (mie_restore),
    .mip_o          (mip),
    .busy_o         (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until trap_req is seen; drops both interrupt lines after 'hold'
  // cycles. Returns the number of steps taken (0 on timeout).
  task automatic wait_trap(input int hold, output int n);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == hold) begin
        t_intr = 1'b0;
        e_intr = 1'b0;
      end
      if (trap_req) begin
        n = k;
        break;
      end
    end
    check_val("trap_seen", 32'(trap_req), 32'd1);
  endtask

  task automatic mret_seq(input string tag);
    mret = 1'b1;
    #1;
    check_val({tag, "_restore"}, 32'(mie_restore), 32'd1);
    check_val({tag, "_busy_mret"}, 32'(busy), 32'd1);
    step();
    mret = 1'b0;
    #1;
    check_val({tag, "_restore_off"}, 32'(mie_restore), 32'd0);
    check_val({tag, "_busy_off"}, 32'(busy), 32'd0);
  endtask

  int n;
  int hits;

  initial begin
    rst_n = 1'b0; t_intr = 1'b0; e_intr = 1'b0;
    mstatus_mie = 1'b1; mtie = 1'b1; meie = 1'b1;
    mtvec = 32'h100; commit_valid = 1'b1; commit_pc = 32'h40; mret = 1'b0;
    repeat (3) step();

    // Reset state
    check_val("rst_trap_req", 32'(trap_req), 32'd0);
    check_val("rst_mip", mip, 32'h0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_mcause", mcause, 32'h0);
    rst_n = 1'b1;
    step();

    // Direct mode, timer
    t_intr = 1'b1;
    wait_trap(2, n);
    check_val("t1_latency", n, 32'd4);
    check_val("t1_trap_pc", trap_pc, 32'h100);
    check_val("t1_mepc", mepc, 32'h40);
    check_val("t1_mepc_we", 32'(mepc_we), 32'd1);
    check_val("t1_mcause", mcause, 32'h8000_0007);
    check_val("t1_mcause_we", 32'(mcause_we), 32'd1);
    check_val("t1_mie_clr", 32'(mie_clr), 32'd1);
    check_val("t1_mip_take", mip, 32'h80);
    step();
    check_val("t1_pulse_end", 32'(trap_req), 32'd0);
    check_val("t1_pc_zero", trap_pc, 32'h0);
    check_val("t1_busy", 32'(busy), 32'd1);
    check_val("t1_mip_clr", mip, 32'h0);
    mret_seq("t1");

    // Vectored mode, external
    mtvec = 32'h101; commit_pc = 32'h200;
    e_intr = 1'b1;
    wait_trap(2, n);
    check_val("t2_latency", n, 32'd4);
    check_val("t2_trap_pc", trap_pc, 32'h12C);
    check_val("t2_mcause", mcause, 32'h8000_000B);
    check_val("t2_mepc", mepc, 32'h200);
    step();
    mret_seq("t2");

    // Simultaneous timer + external, direct mode
    mtvec = 32'h100; commit_pc = 32'h44;
    t_intr = 1'b1; e_intr = 1'b1;
    wait_trap(2, n);
    check_val("t3_latency", n, 32'd4);
    check_val("t3_mcause_ext", mcause, 32'h8000_000B);
    check_val("t3_trap_pc", trap_pc, 32'h100);
    step();
    check_val("t3_mip_handler", mip, 32'h80);
    hits = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (trap_req) hits++;
    end
    check_val("t3_no_nested", hits, 32'd0);
    mret_seq("t3");
    check_val("t3_idle_gap", 32'(trap_req), 32'd0);
    wait_trap(0, n);
    check_val("t3_rearm_latency", n, 32'd1);
    check_val("t3_mcause_tmr", mcause, 32'h8000_0007);
    step();
    check_val("t3_mip_empty", mip, 32'h0);
    mret_seq("t3b");

    // Masked interrupt
    mstatus_mie = 1'b0; commit_pc = 32'h48;
    t_intr = 1'b1;
    hits = 0;
    for (int k = 1; k <= 50; k++) begin
      step();
      if (k == 2) t_intr = 1'b0;
      if (trap_req) hits++;
    end
    check_val("t4_masked_hits", hits, 32'd0);
    check_val("t4_mip_pending", mip, 32'h80);
    mstatus_mie = 1'b1;
    wait_trap(0, n);
    check_val("t4_unmask_latency", n, 32'd1);
    check_val("t4_mepc", mepc, 32'h48);
    step();
    mret_seq("t4");

    // Bubble hold
    commit_valid = 1'b0;
    t_intr = 1'b1;
    hits = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      commit_pc = 32'h60 + 32'(k * 4);
      if (k == 2) t_intr = 1'b0;
      if (trap_req) hits++;
    end
    check_val("t5_bubble_hits", hits, 32'd0);
    commit_pc = 32'h88; commit_valid = 1'b1;
    #1;
    check_val("t5_fire", 32'(trap_req), 32'd1);
    check_val("t5_mepc", mepc, 32'h88);
    check_val("t5_mcause", mcause, 32'h8000_0007);
    step();
    mret_seq("t5");

    // Reset while ARMED
    commit_valid = 1'b0;
    t_intr = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 2) t_intr = 1'b0;
    end
    check_val("t6_mip_pre", mip, 32'h80);
    commit_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check_val("t6_trap_req", 32'(trap_req), 32'd0);
    check_val("t6_mip", mip, 32'h0);
    check_val("t6_mepc", mepc, 32'h0);
    check_val("t6_mie_clr", 32'(mie_clr), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    hits = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (trap_req) hits++;
    end
    check_val("t6_no_trap_after", hits, 32'd0);
    check_val("t6_mip_after", mip, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_trap_ctrl
`default_nettype wire
